spectro_readout_seq: RTL and testbench
======================================

SPECTRO_READOUT_SEQ -- requirements
Module: spectro_readout_seq

Interface
REQ-001 SHALL provide parameter DEPTH, default 200, words per memory bank (2..2**ADDR_W).
REQ-002 SHALL provide parameter ADDR_W, default 8, bank-local address width.
REQ-003 SHALL provide parameter TS_BITS, default 31, timestamp bits shifted per frame (>=2).
REQ-004 SHALL provide parameter WORD_BITS, default 2, serial shift cycles per memory word (>=1).
REQ-005 SHALL have ports:
  clk  input  1  rising-edge clock
  rst_n  input  1  reset, asynchronous, active-low
  bank_full_i  input  1  one-cycle pulse: current write bank completely filled
  acq_done_i  input  1  one-cycle pulse: acquisition ended
  last_idx_i  input  ADDR_W  last written address of the current write bank; valid with acq_done_i
  ts_load_o  output  1  load timestamp into shift register
  word_load_o  output  1  load memory word into shift register
  shift_o  output  1  shift one serial bit
  sel_data_o  output  1  0 = timestamp path, 1 = memory path
  re_o  output  1  memory read enable
  addr_o  output  ADDR_W+1  {read bank, word index}
  busy_o  output  1  frame in progress
  frame_end_o  output  1  one-cycle pulse on the final shift of a frame
  overflow_o  output  1  sticky: a job was dropped
  state_o  output  3  current FSM state code

Function
REQ-006 SHALL keep write-bank bit wb (reset 0): toggles on bank_full_i; forced to 0 after acq_done_i.
REQ-007 SHALL keep a 2-entry FIFO of jobs {bank, end_idx, last}.
REQ-008 bank_full_i alone SHALL push {wb, DEPTH-1, 0}.
REQ-009 acq_done_i alone SHALL push {wb, last_idx_i, 1}.
REQ-010 Simultaneous bank_full_i and acq_done_i SHALL push one job {wb, DEPTH-1, 1}; last_idx_i ignored.
REQ-011 A push with FIFO full SHALL be dropped and set overflow_o; overflow_o clears only on reset.
REQ-012 A pop and a push in the same cycle SHALL both take effect; the pushed job is not considered full-dropped.
REQ-013 FSM states with codes: IDLE=0, TS_LOAD=1, TS_SHIFT=2, WORD_LOAD=3, WORD_SHIFT=4, BANK_WAIT=5.
REQ-014 IDLE: FIFO non-empty -> TS_LOAD next cycle; head job popped on leaving TS_SHIFT.
REQ-015 TS_LOAD: ts_load_o=1, sel_data_o=0, one cycle -> TS_SHIFT.
REQ-016 TS_SHIFT: shift_o=1, sel_data_o=0, exactly TS_BITS cycles -> WORD_LOAD, index=0.
REQ-017 WORD_LOAD: word_load_o=1, re_o=1, sel_data_o=1, addr_o={job bank, index}, one cycle -> WORD_SHIFT.
REQ-018 WORD_SHIFT: shift_o=1, sel_data_o=1, exactly WORD_BITS cycles; then index<end_idx -> index+1, WORD_LOAD.
REQ-019 WORD_SHIFT end with index==end_idx: last=1 -> IDLE with frame_end_o on final shift cycle; last=0 -> BANK_WAIT.
REQ-020 BANK_WAIT: sel_data_o=1, outputs otherwise 0; FIFO non-empty -> pop, WORD_LOAD with index 0, no timestamp.
REQ-021 Timestamp SHALL be sent once per acquisition, only when leaving IDLE.
REQ-022 busy_o SHALL be 1 in every state except IDLE.
REQ-023 ts_load_o, word_load_o, shift_o, re_o SHALL be mutually exclusive in any cycle.
REQ-024 Index and shift counters SHALL saturate-free wrap only via explicit reload; end_idx>=DEPTH SHALL be clamped to DEPTH-1.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, FIFO empty, wb=0, index=0, counters=0, overflow_o=0, all outputs 0.
REQ-026 rst_n low mid-frame SHALL abort the frame without frame_end_o; on release the block stays in IDLE until a new push.

Verification
REQ-027 Short acquisition: acq_done_i with last_idx_i=4, defaults -> busy_o 1 for 1+31+5*3=47 cycles, addr_o 0..4 bank 0, frame_end_o once.
REQ-028 Long acquisition: bank_full_i, later acq_done_i with last_idx_i=9 -> 31 timestamp shifts, 200 words bank 0, BANK_WAIT, 10 words bank 1, one frame_end_o.
REQ-029 Overflow: three pushes before first pop -> third dropped, overflow_o=1 held until rst_n low.
REQ-030 Coincident bank_full_i and acq_done_i -> single job, 200 words read, frame_end_o after word 199.
REQ-031 Assert rst_n low during WORD_SHIFT at index 50 -> all outputs 0 immediately, state_o=0, no frame_end_o.
REQ-032 Parameter sweep DEPTH=16, WORD_BITS=4, TS_BITS=8 full bank -> 1+8+16*5=89 busy cycles to BANK_WAIT.

Source files
------------

// File: rtl/spectro_readout_if.sv
// +----------------------------------------------------------------------+
// | spectro_readout_if : job requests in, readout sequencing signals out |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface spectro_readout_if #(
  parameter int ADDR_W = 8
);
  logic              bank_full_i;
  logic              acq_done_i;
  logic [ADDR_W-1:0] last_idx_i;
  logic              ts_load_o;
  logic              word_load_o;
  logic              shift_o;
  logic              sel_data_o;
  logic              re_o;
  logic [ADDR_W:0]   addr_o;
  logic              busy_o;
  logic              frame_end_o;
  logic              overflow_o;
  logic [2:0]        state_o;

  modport master (
    output bank_full_i, acq_done_i, last_idx_i,
    input  ts_load_o, word_load_o, shift_o, sel_data_o, re_o, addr_o,
           busy_o, frame_end_o, overflow_o, state_o
  );

  modport slave (
    input  bank_full_i, acq_done_i, last_idx_i,
    output ts_load_o, word_load_o, shift_o, sel_data_o, re_o, addr_o,
           busy_o, frame_end_o, overflow_o, state_o
  );
endinterface

`default_nettype wire

// File: rtl/spectro_readout_seq.sv
// +----------------------------------------------------------------------+
// | spectro_readout_seq : queues bank read jobs, serialises timestamp    |
// | and memory words into a shift register. Revision 1.0                 |
// +----------------------------------------------------------------------+
`default_nettype none

module spectro_readout_seq #(
  parameter int DEPTH     = 200,
  parameter int ADDR_W    = 8,
  parameter int TS_BITS   = 31,
  parameter int WORD_BITS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  spectro_readout_if.slave  bus
);

  localparam int MAX_BITS = (TS_BITS > WORD_BITS) ? TS_BITS : WORD_BITS;
  localparam int CNT_W    = $clog2(MAX_BITS) + 1;

  localparam logic [CNT_W-1:0]  TS_LAST   = CNT_W'(TS_BITS - 1);
  localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(WORD_BITS - 1);
  localparam logic [ADDR_W-1:0] END_MAX   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    TS_LOAD    = 3'd1,
    TS_SHIFT   = 3'd2,
    WORD_LOAD  = 3'd3,
    WORD_SHIFT = 3'd4,
    BANK_WAIT  = 3'd5
  } state_t;

  typedef struct packed {
    logic              bank;
    logic [ADDR_W-1:0] end_idx;
    logic              last;
  } job_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  job_t              cur_q, cur_d;
  job_t              fifo_q [2];
  job_t              fifo_d [2];
  logic [1:0]        fcnt_q, fcnt_d;
  logic              wb_q, wb_d;
  logic              ovf_q, ovf_d;

  logic              push;
  logic              pop;
  job_t              push_job;
  logic [1:0]        fill;

  logic              ts_load;
  logic              word_load;
  logic              shift;
  logic              sel_data;
  logic              re;
  logic              busy;
  logic              frame_end;
  logic [ADDR_W:0]   addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      cur_q     <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      fcnt_q    <= '0;
      wb_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      cur_q     <= cur_d;
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
      fcnt_q    <= fcnt_d;
      wb_q      <= wb_d;
      ovf_q     <= ovf_d;
    end
  end

  // A coincident bank_full/acq_done closes a completely filled bank.
  always_comb begin
    push             = bus.bank_full_i | bus.acq_done_i;
    push_job.bank    = wb_q;
    push_job.last    = bus.acq_done_i;
    push_job.end_idx = END_MAX;
    if (bus.acq_done_i && !bus.bank_full_i && ({1'b0, bus.last_idx_i} < DEPTH_EXT)) begin
      push_job.end_idx = bus.last_idx_i;
    end
  end

  always_comb begin
    wb_d = wb_q;
    if (bus.acq_done_i) begin
      wb_d = 1'b0;
    end else if (bus.bank_full_i) begin
      wb_d = ~wb_q;
    end
  end

  // Pop frees the head first, so a same-cycle push into a full FIFO survives.
  always_comb begin
    fifo_d[0] = fifo_q[0];
    fifo_d[1] = fifo_q[1];
    ovf_d     = ovf_q;
    fill      = fcnt_q;
    if (pop) begin
      fifo_d[0] = fifo_q[1];
      fill      = fcnt_q - 2'd1;
    end
    if (push) begin
      if (fill == 2'd2) begin
        ovf_d = 1'b1;
      end else begin
        if (fill == 2'd0) begin
          fifo_d[0] = push_job;
        end else begin
          fifo_d[1] = push_job;
        end
        fill = fill + 2'd1;
      end
    end
    fcnt_d = fill;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    cur_d     = cur_q;
    pop       = 1'b0;
    ts_load   = 1'b0;
    word_load = 1'b0;
    shift     = 1'b0;
    sel_data  = 1'b0;
    re        = 1'b0;
    busy      = 1'b1;
    frame_end = 1'b0;
    addr      = '0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (fcnt_q != 2'd0) begin
          state_d = TS_LOAD;
        end
      end
      TS_LOAD: begin
        ts_load = 1'b1;
        cnt_d   = '0;
        state_d = TS_SHIFT;
      end
      TS_SHIFT: begin
        shift = 1'b1;
        if (cnt_q == TS_LAST) begin
          pop     = 1'b1;
          cur_d   = fifo_q[0];
          idx_d   = '0;
          state_d = WORD_LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WORD_LOAD: begin
        word_load = 1'b1;
        re        = 1'b1;
        sel_data  = 1'b1;
        addr      = {cur_q.bank, idx_q};
        cnt_d     = '0;
        state_d   = WORD_SHIFT;
      end
      WORD_SHIFT: begin
        shift    = 1'b1;
        sel_data = 1'b1;
        if (cnt_q == WORD_LAST) begin
          if (idx_q < cur_q.end_idx) begin
            idx_d   = idx_q + 1'b1;
            state_d = WORD_LOAD;
          end else if (cur_q.last) begin
            frame_end = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = BANK_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BANK_WAIT: begin
        sel_data = 1'b1;
        if (fcnt_q != 2'd0) begin
          pop     = 1'b1;
          cur_d   = fifo_q[0];
          idx_d   = '0;
          state_d = WORD_LOAD;
        end
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ts_load_o   = ts_load;
  assign bus.word_load_o = word_load;
  assign bus.shift_o     = shift;
  assign bus.sel_data_o  = sel_data;
  assign bus.re_o        = re;
  assign bus.addr_o      = addr;
  assign bus.busy_o      = busy;
  assign bus.frame_end_o = frame_end;
  assign bus.overflow_o  = ovf_q;
  assign bus.state_o     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_spectro_readout_seq.sv
// +----------------------------------------------------------------------+
// | tb_spectro_readout_seq : directed table, corner sequences and random |
// | pulses against a frame-expansion reference model. Revision 1.0       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_spectro_readout_seq;

  localparam int D   = 200;
  localparam int AW  = 8;
  localparam int TSB = 31;
  localparam int WB  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spectro_readout_if #(.ADDR_W(AW)) bus ();
  spectro_readout_if #(.ADDR_W(4))  bus2 ();

  spectro_readout_seq #(.DEPTH(D), .ADDR_W(AW), .TS_BITS(TSB), .WORD_BITS(WB)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  spectro_readout_seq #(.DEPTH(16), .ADDR_W(4), .TS_BITS(8), .WORD_BITS(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
  );

  typedef struct packed {
    logic ts, wl, sh, sel, re;
    logic [AW:0] addr;
    logic busy, fe;
    logic [2:0] st;
  } obs_t;

  typedef struct packed { obs_t o; logic pop; } step_t;
  typedef struct packed { logic bank; int end_idx; logic last; } job_t;

  typedef struct {
    bit bf; bit ad; int idx;
    int exp_busy; int exp_words; int exp_fe; int exp_last;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a queue of accepted jobs and a queue of expected cycles.
  step_t plan[$];
  job_t  jq[$];
  bit    m_wait, m_wb, m_ovf;

  int          n_busy, n_words, n_fe, n_ts;
  logic [AW:0] last_addr;
  obs_t        cur_obs;

  function automatic obs_t get_obs();
    obs_t o;
    o.ts   = bus.ts_load_o;   o.wl  = bus.word_load_o; o.sh = bus.shift_o;
    o.sel  = bus.sel_data_o;  o.re  = bus.re_o;        o.addr = bus.addr_o;
    o.busy = bus.busy_o;      o.fe  = bus.frame_end_o; o.st = bus.state_o;
    return o;
  endfunction

  function automatic void chk(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    plan.delete();
    jq.delete();
    m_wait = 1'b0; m_wb = 1'b0; m_ovf = 1'b0;
  endfunction

  function automatic void expand_ts();
    step_t s;
    for (int i = 0; i <= TSB; i++) begin
      s = '0;
      s.o.busy = 1'b1;
      if (i == 0) begin
        s.o.ts = 1'b1; s.o.st = 3'd1;
      end else begin
        s.o.sh = 1'b1; s.o.st = 3'd2; s.pop = (i == TSB);
      end
      plan.push_back(s);
    end
  endfunction

  function automatic void expand_words(job_t j);
    step_t s;
    for (int w = 0; w <= j.end_idx; w++) begin
      s = '0;
      s.o.busy = 1'b1; s.o.wl = 1'b1; s.o.re = 1'b1; s.o.sel = 1'b1; s.o.st = 3'd3;
      s.o.addr = {j.bank, w[AW-1:0]};
      plan.push_back(s);
      for (int b = 1; b <= WB; b++) begin
        s = '0;
        s.o.busy = 1'b1; s.o.sh = 1'b1; s.o.sel = 1'b1; s.o.st = 3'd4;
        s.o.fe = j.last && (w == j.end_idx) && (b == WB);
        plan.push_back(s);
      end
    end
    m_wait = !j.last;
  endfunction

  function automatic void model_cycle(input bit bf, input bit ad, input int li,
                                      output obs_t e, output bit eo);
    step_t s;
    job_t  j;
    eo = m_ovf;
    e  = '0;
    if (plan.size() > 0) begin
      s = plan.pop_front();
      e = s.o;
      if (s.pop) void'(jq.pop_front());
    end else if (m_wait) begin
      e.busy = 1'b1; e.sel = 1'b1; e.st = 3'd5;
      if (jq.size() > 0) begin
        j = jq.pop_front();
        expand_words(j);
      end
    end else if (jq.size() > 0) begin
      expand_ts();
      expand_words(jq[0]);
    end
    if (bf || ad) begin
      j.bank    = m_wb;
      j.last    = ad;
      j.end_idx = (ad && !bf) ? ((li >= D) ? D - 1 : li) : D - 1;
      if (jq.size() >= 2) m_ovf = 1'b1;
      else jq.push_back(j);
    end
    if (ad) m_wb = 1'b0;
    else if (bf) m_wb = ~m_wb;
  endfunction

  function automatic void clr_stats();
    n_busy = 0; n_words = 0; n_fe = 0; n_ts = 0; last_addr = '0;
  endfunction

  task automatic tick(input bit bf, input bit ad, input int li);
    obs_t e, a;
    bit   eo;
    @(posedge clk);
    #1;
    bus.bank_full_i = bf;
    bus.acq_done_i  = ad;
    bus.last_idx_i  = li[AW-1:0];
    model_cycle(bf, ad, li, e, eo);
    @(negedge clk);
    a = get_obs();
    cyc++;
    total++;
    if (a !== e) begin
      bad++;
      if (bad < 40) $display("FAIL cycle %0d outputs: got %h expected %h", cyc, a, e);
    end
    total++;
    if (bus.overflow_o !== eo) begin
      bad++;
      if (bad < 40) $display("FAIL cycle %0d overflow: got %b expected %b", cyc, bus.overflow_o, eo);
    end
    if (a.busy) n_busy++;
    if (a.wl) begin n_words++; last_addr = a.addr; end
    if (a.fe) n_fe++;
    if (a.st == 3'd2) n_ts++;
    cur_obs = a;
  endtask

  task automatic run_to_idle(input string nm, input int budget);
    bit done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick(1'b0, 1'b0, 0);
      if (!cur_obs.busy && n_busy > 0) begin done = 1'b1; break; end
    end
    chk({nm, " reached idle"}, done, 1);
  endtask

  // Called at a negedge so reset lands inside the cycle just observed.
  task automatic async_reset(input string nm);
    obs_t a;
    bus.bank_full_i = 1'b0; bus.acq_done_i = 1'b0; bus.last_idx_i = '0;
    rst_n = 1'b0;
    #1;
    a = get_obs();
    total++;
    if (a !== '0) begin
      bad++;
      $display("FAIL %s reset outputs: got %h expected 0", nm, a);
    end
    chk({nm, " reset overflow"}, bus.overflow_o, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs[6];

  initial begin
    bit          done;
    int          b2, w2, t2;
    logic [4:0]  last2;
    bit          bf, ad;
    int          r;

    vecs[0] = '{1'b0, 1'b1,   4,  47,   5, 1,   4};
    vecs[1] = '{1'b0, 1'b1,   0,  35,   1, 1,   0};
    vecs[2] = '{1'b1, 1'b1,   7, 632, 200, 1, 199};
    vecs[3] = '{1'b0, 1'b1, 250, 632, 200, 1, 199};
    vecs[4] = '{1'b0, 1'b1, 199, 632, 200, 1, 199};
    vecs[5] = '{1'b0, 1'b1, 100, 335, 101, 1, 100};

    rst_n = 1'b0;
    bus.bank_full_i  = 1'b0; bus.acq_done_i  = 1'b0; bus.last_idx_i  = '0;
    bus2.bank_full_i = 1'b0; bus2.acq_done_i = 1'b0; bus2.last_idx_i = '0;
    model_reset();
    clr_stats();
    #3;
    chk("reset state main", get_obs(), 0);
    chk("reset overflow main", bus.overflow_o, 0);
    chk("reset busy small", bus2.busy_o, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reduced-parameter instance: one full bank straight into BANK_WAIT.
    @(posedge clk); #1 bus2.bank_full_i = 1'b1;
    @(posedge clk); #1 bus2.bank_full_i = 1'b0;
    done = 1'b0; b2 = 0; w2 = 0; t2 = 0; last2 = '0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (bus2.state_o == 3'd5) begin done = 1'b1; break; end
      if (bus2.busy_o) b2++;
      if (bus2.shift_o && !bus2.sel_data_o) t2++;
      if (bus2.word_load_o) begin w2++; last2 = bus2.addr_o; end
    end
    chk("small reached bank_wait", done, 1);
    chk("small busy cycles", b2, 89);
    chk("small words", w2, 16);
    chk("small ts shifts", t2, 8);
    chk("small last addr", last2, 15);

    for (int i = 0; i < 6; i++) begin
      clr_stats();
      tick(vecs[i].bf, vecs[i].ad, vecs[i].idx);
      run_to_idle($sformatf("vec%0d", i), 2000);
      chk($sformatf("vec%0d busy", i), n_busy, vecs[i].exp_busy);
      chk($sformatf("vec%0d words", i), n_words, vecs[i].exp_words);
      chk($sformatf("vec%0d frame_end", i), n_fe, vecs[i].exp_fe);
      chk($sformatf("vec%0d last addr", i), last_addr, vecs[i].exp_last);
      chk($sformatf("vec%0d ts shifts", i), n_ts, TSB);
    end

    // Long acquisition spanning two banks.
    clr_stats();
    tick(1'b1, 1'b0, 0);
    done = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      tick(1'b0, 1'b0, 0);
      if (cur_obs.st == 3'd5) begin done = 1'b1; break; end
    end
    chk("long reached bank_wait", done, 1);
    chk("long busy incl first wait", n_busy, 1 + TSB + D * (1 + WB) + 1);
    chk("long bank0 words", n_words, D);
    chk("long no frame_end yet", n_fe, 0);
    repeat (10) tick(1'b0, 1'b0, 0);
    clr_stats();
    tick(1'b0, 1'b1, 9);
    run_to_idle("long tail", 200);
    chk("long bank1 words", n_words, 10);
    chk("long bank1 last addr", last_addr, 9'h109);
    chk("long no second ts", n_ts, 0);
    chk("long frame_end", n_fe, 1);

    // Three pushes before the first pop.
    clr_stats();
    tick(1'b1, 1'b0, 0);
    tick(1'b1, 1'b0, 0);
    tick(1'b1, 1'b0, 0);
    tick(1'b0, 1'b0, 0);
    chk("overflow set", bus.overflow_o, 1);
    repeat (1400) tick(1'b0, 1'b0, 0);
    chk("overflow held", bus.overflow_o, 1);
    chk("overflow words", n_words, 2 * D);
    chk("overflow parked", cur_obs.st, 5);
    async_reset("overflow");

    // Reset while shifting word 50.
    clr_stats();
    tick(1'b0, 1'b1, 120);
    done = 1'b0;
    for (int k = 0; k < 500; k++) begin
      tick(1'b0, 1'b0, 0);
      if (cur_obs.wl && cur_obs.addr[AW-1:0] == 8'd50) begin done = 1'b1; break; end
    end
    chk("midreset reached word50", done, 1);
    tick(1'b0, 1'b0, 0);
    chk("midreset in word_shift", cur_obs.st, 4);
    async_reset("midframe");
    chk("midreset no frame_end", n_fe, 0);
    clr_stats();
    repeat (20) tick(1'b0, 1'b0, 0);
    chk("midreset stays idle", n_busy, 0);

    // Random pulse traffic, with one asynchronous reset halfway.
    for (int k = 0; k < 6000; k++) begin
      r  = $urandom_range(0, 999);
      bf = (r < 6);
      ad = (r >= 6 && r < 10) || (r == 0);
      tick(bf, ad, $urandom_range(0, 255));
      if (k == 3000) async_reset("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
